// File: rtl/serializador_pkg.sv
// Shared types for the queue-to-serial reader: FSM state encoding and counter sizing.
package serializador_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StLoad,
        StShift
    } state_e;

    // Counter must reach DATA_WIDTH so it needs one bit beyond log2.
    function automatic int unsigned cnt_width(int unsigned data_width);
        return $clog2(data_width) + 1;
    endfunction

endpackage

// File: rtl/serializador_if.sv
// Queue-side pop interface plus the serial valid/ready line toward the line driver.
interface serializador_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();

    logic [7:0]            len_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  dequeue_out;
    logic                  serial_out;
    logic                  serial_valid_out;
    logic                  serial_ready_in;
    logic                  frame_start_out;

    modport master (
        input  len_in,
        input  data_in,
        input  serial_ready_in,
        output dequeue_out,
        output serial_out,
        output serial_valid_out,
        output frame_start_out
    );

    modport slave (
        output len_in,
        output data_in,
        output serial_ready_in,
        input  dequeue_out,
        input  serial_out,
        input  serial_valid_out,
        input  frame_start_out
    );

endinterface

// File: rtl/serializador_shift_reg_piso.sv
// Parallel-in serial-out shift register; load wins over shift, direction fixed by MSB_FIRST.
module serializador_shift_reg_piso #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                  clock_10khz,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  shift_i,
    output logic                  bit_o
);

    logic [DATA_WIDTH-1:0] shreg_d, shreg_q;

    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = data_i;
        end else if (shift_i) begin
            if (MSB_FIRST) begin
                shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
            end else begin
                shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clock_10khz or negedge reset) begin
        if (!reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign bit_o = MSB_FIRST ? shreg_q[DATA_WIDTH-1] : shreg_q[0];

endmodule

// File: rtl/serializador.sv
// Pops one byte per frame from the queue and presents it bit by bit on a valid/ready line.
module serializador
    import serializador_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                  clock_10khz,
    input  logic                  reset,
    input  logic                  enable_in,
    serializador_if.master        ser_bus,
    output logic                  busy_out,
    output logic [7:0]            frames_sent_out
);

    localparam int unsigned CntWidth = cnt_width(DATA_WIDTH);
    localparam logic [CntWidth-1:0] LastBit = CntWidth'(DATA_WIDTH - 1);

    state_e              state_d, state_q;
    logic [CntWidth-1:0] cnt_d, cnt_q;
    logic [7:0]          frames_d, frames_q;
    logic                load;
    logic                shift;
    logic                ser_bit;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        frames_d = frames_q;
        load     = 1'b0;
        shift    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable_in && (ser_bus.len_in != 8'd0)) begin
                    state_d = StReq;
                end
            end
            // Queue presents the popped byte on data_in from the next cycle.
            StReq: begin
                state_d = StLoad;
            end
            StLoad: begin
                load    = 1'b1;
                cnt_d   = '0;
                state_d = StShift;
            end
            StShift: begin
                if (ser_bus.serial_ready_in) begin
                    shift = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastBit) begin
                        frames_d = frames_q + 8'd1;
                        state_d  = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock_10khz or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            frames_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            frames_q <= frames_d;
        end
    end

    serializador_shift_reg_piso #(
        .DATA_WIDTH (DATA_WIDTH),
        .MSB_FIRST  (MSB_FIRST)
    ) u_piso (
        .clock_10khz (clock_10khz),
        .reset       (reset),
        .load_i      (load),
        .data_i      (ser_bus.data_in),
        .shift_i     (shift),
        .bit_o       (ser_bit)
    );

    // Every output is decoded from registered state only.
    assign ser_bus.dequeue_out      = (state_q == StReq);
    assign ser_bus.serial_valid_out = (state_q == StShift);
    assign ser_bus.serial_out       = (state_q == StShift) && ser_bit;
    assign ser_bus.frame_start_out  = (state_q == StShift) && (cnt_q == '0);
    assign busy_out                 = (state_q != StIdle);
    assign frames_sent_out          = frames_q;

endmodule

// File: tb/tb_serializador.sv
// Scoreboard bench: MSB-first and LSB-first instances fed by one queue model, checked per bit.
module tb_serializador;

    localparam int unsigned DW = 8;

    typedef struct packed {
        logic msb;
        logic lsb;
        logic first;
        logic last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          ready = 1'b0;
    logic [7:0]    len = 8'd0;
    logic [DW-1:0] data = '0;
    logic          busy0, busy1;
    logic [7:0]    fs0, fs1;

    exp_t       exp_q[$];
    logic [7:0] byte_q[$];
    logic [7:0] exp_frames = 8'd0;
    int         checks = 0;
    int         errors = 0;
    bit         done = 1'b0;
    bit         timeout = 1'b0;
    bit         b2b_mode = 1'b0;

    always #5 clk = ~clk;

    serializador_if #(.DATA_WIDTH(DW)) if0 ();
    serializador_if #(.DATA_WIDTH(DW)) if1 ();

    assign if0.len_in          = len;
    assign if0.data_in         = data;
    assign if0.serial_ready_in = ready;
    assign if1.len_in          = len;
    assign if1.data_in         = data;
    assign if1.serial_ready_in = ready;

    serializador #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1)) u_msb (
        .clock_10khz     (clk),
        .reset           (rst_n),
        .enable_in       (enable),
        .ser_bus         (if0),
        .busy_out        (busy0),
        .frames_sent_out (fs0)
    );

    serializador #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0)) u_lsb (
        .clock_10khz     (clk),
        .reset           (rst_n),
        .enable_in       (enable),
        .ser_bus         (if1),
        .busy_out        (busy1),
        .frames_sent_out (fs1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [7:0] b);
        byte_q.push_back(b);
        len = 8'(byte_q.size());
    endtask

    // One clock; the queue model answers a pop by showing the head byte from the next cycle.
    task automatic tick();
        logic deq;
        exp_t e;
        @(negedge clk);
        deq = if0.dequeue_out;
        @(posedge clk);
        #1;
        if (deq && rst_n) begin
            if (byte_q.size() != 0) begin
                data = byte_q.pop_front();
                for (int i = 0; i < DW; i++) begin
                    e.msb   = data[DW-1-i];
                    e.lsb   = data[i];
                    e.first = (i == 0);
                    e.last  = (i == DW - 1);
                    exp_q.push_back(e);
                end
            end
            len = 8'(byte_q.size());
        end
    endtask

    initial begin
        int pushed;
        int budget;
        enable = 1'b1;
        ready  = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();

        push(8'hA5);
        repeat (15) tick();

        push(8'h3C);
        repeat (6) tick();
        ready = 1'b0;
        repeat (5) tick();
        ready = 1'b1;
        repeat (10) tick();

        b2b_mode = 1'b1;
        push(8'h01);
        push(8'h80);
        repeat (30) tick();
        b2b_mode = 1'b0;

        push(8'hFF);
        repeat (7) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        push(8'h01);
        repeat (15) tick();

        pushed = 0;
        budget = 0;
        while ((pushed < 300 || byte_q.size() != 0) && budget < 40000) begin
            if (pushed < 300 && byte_q.size() < 3 && $urandom_range(0, 3) == 0) begin
                push(8'($urandom));
                pushed++;
            end
            enable = ($urandom_range(0, 9) != 0);
            ready  = ($urandom_range(0, 3) != 0);
            tick();
            budget++;
        end
        if (budget >= 40000) timeout = 1'b1;
        enable = 1'b1;
        ready  = 1'b1;
        repeat (20) tick();
        done = 1'b1;
    end

    initial begin
        int   cyc;
        int   deq_cyc;
        bit   prev_deq_b2b;
        bit   exp_valid;
        exp_t e;
        cyc = 0;
        deq_cyc = -100;
        prev_deq_b2b = 1'b0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (done) break;
            if (!rst_n) begin
                #1;
                chk("rst_outs_msb", {if0.dequeue_out, if0.serial_out, if0.serial_valid_out,
                                     if0.frame_start_out, busy0, fs0}, 0);
                chk("rst_outs_lsb", {if1.dequeue_out, if1.serial_out, if1.serial_valid_out,
                                     if1.frame_start_out, busy1, fs1}, 0);
                exp_q.delete();
                exp_frames = 8'd0;
                deq_cyc = -100;
                prev_deq_b2b = 1'b0;
                continue;
            end
            cyc++;
            // A popped frame becomes visible two cycles after its pop request.
            exp_valid = (exp_q.size() != 0) && (cyc - deq_cyc >= 2);
            chk("frames_msb", fs0, exp_frames);
            chk("frames_lsb", fs1, exp_frames);
            chk("valid_msb", if0.serial_valid_out, exp_valid);
            chk("valid_lsb", if1.serial_valid_out, exp_valid);
            if (exp_valid) chk("busy_shift", {busy0, busy1}, 2'b11);
            if (if0.dequeue_out) begin
                chk("deq_once_msb", exp_q.size(), 0);
                chk("deq_len_nonzero", (len != 8'd0), 1);
                if (b2b_mode && prev_deq_b2b) chk("b2b_gap", cyc - deq_cyc, DW + 3);
                deq_cyc = cyc;
                prev_deq_b2b = b2b_mode;
            end
            if (if1.dequeue_out) chk("deq_once_lsb", exp_q.size(), 0);
            if (exp_valid) begin
                e = exp_q[0];
                if (ready) begin
                    void'(exp_q.pop_front());
                    chk("bit_msb", if0.serial_out, e.msb);
                    chk("bit_lsb", if1.serial_out, e.lsb);
                    chk("start_msb", if0.frame_start_out, e.first);
                    chk("start_lsb", if1.frame_start_out, e.first);
                    if (e.last) exp_frames = exp_frames + 8'd1;
                end else begin
                    chk("stall_bit_msb", if0.serial_out, e.msb);
                    chk("stall_bit_lsb", if1.serial_out, e.lsb);
                end
            end else begin
                chk("idle_bit_msb", {if0.serial_out, if0.frame_start_out}, 0);
                chk("idle_bit_lsb", {if1.serial_out, if1.frame_start_out}, 0);
            end
        end
        chk("stimulus_timeout", timeout, 0);
        chk("leftover_bits", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d",
                 checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
